exec_ctrl: RTL and testbench
============================

EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter RUN_DIV, default 1, clk cycles per cpu_en pulse in run mode (legal 1..2^24).
REQ-002 Parameter STEP_CYCLES, default 1, cpu_en cycles issued per single step (legal 1..15).
REQ-003 Port list:
- clk  in  1  system clock, 100 MHz board clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level switch; 1 = free-run request.
- step  in  1  debounced step key, level.
- pc  in  32  current IF-stage PC.
- bp_addr  in  32  breakpoint address.
- bp_valid  in  1  breakpoint armed.
- cpu_en  out  1  pipeline advance enable, one clk per pulse.
- state  out  2  FSM state code.
- cycle_cnt  out  32  count of issued cpu_en cycles.
- break_hit  out  1  high while halted on breakpoint.

Function
REQ-004 The FSM SHALL have states IDLE=00, RUN=01, STEP=10, BREAK=11, driven on state.
REQ-005 step_rise SHALL equal step AND NOT step_q, where step_q is step registered on clk.
REQ-006 In IDLE, run=1 SHALL move to RUN next cycle; otherwise step_rise SHALL move to STEP.
REQ-007 If run=1 and step_rise coincide in IDLE, the FSM SHALL enter RUN and discard the step.
REQ-008 In STEP, cpu_en SHALL be high for exactly STEP_CYCLES consecutive cycles, beginning the first cycle in STEP; the FSM SHALL then return to IDLE.
REQ-009 In STEP, step_rise and run SHALL be ignored, and no breakpoint compare SHALL occur.
REQ-010 In RUN, a divider SHALL count 0..RUN_DIV-1; cpu_en SHALL be high when the count equals RUN_DIV-1, giving every cycle when RUN_DIV=1.
REQ-011 In RUN, run=0 SHALL move to IDLE next cycle and clear the divider; cpu_en SHALL be low in that cycle; step_rise SHALL be ignored.
REQ-012 In RUN, if a cpu_en cycle would occur while bp_valid=1 and pc==bp_addr, that cpu_en SHALL be suppressed and the FSM SHALL enter BREAK next cycle.
REQ-013 In BREAK, cpu_en SHALL be 0 and break_hit SHALL be 1.
REQ-014 BREAK SHALL exit on run=0 to IDLE, or on step_rise to STEP; run=0 has priority.
REQ-015 After a STEP entered from BREAK, a still-high run SHALL resume RUN via IDLE.
REQ-016 cpu_en SHALL be 0 in IDLE and BREAK.
REQ-017 cycle_cnt SHALL increment by 1 on every cycle with cpu_en=1, wrapping from 0xFFFFFFFF to 0.
REQ-018 break_hit SHALL be 0 in every state except BREAK.

Reset
REQ-019 reset=1 SHALL asynchronously force state=IDLE, cpu_en=0, cycle_cnt=0, break_hit=0, divider=0, and step-cycle counter=0.
REQ-020 step_q SHALL reset to 1, so a key held through reset release issues no step.
REQ-021 Reset asserted mid-STEP or mid-RUN SHALL abort immediately, with no further cpu_en pulses.

Configuration
REQ-022 Macro EXEC_CTRL_BREAKPOINT_EN defined: REQ-012 to REQ-015 apply.
REQ-023 Macro EXEC_CTRL_BREAKPOINT_EN undefined: bp_addr and bp_valid SHALL be ignored, BREAK SHALL be unreachable, break_hit SHALL be constant 0, and the ports SHALL remain present.

Structure
REQ-024 State encodings and the STEP_CYCLES counter width SHALL reside in shared package cpu_ctrl_pkg.
REQ-025 Edge detection SHALL be a sub-module rise_detect (clk, reset, in, rise), whose register resets to 1.

Verification
REQ-026 With run=0, one step pulse and STEP_CYCLES=1: cpu_en is high exactly 1 cycle, cycle_cnt=1, state returns to 00.
REQ-027 With run=1 and RUN_DIV=4 for 40 cycles: cpu_en pulses 10 times, spaced 4 apart; deasserting run gives state 00 the next cycle.
REQ-028 Macro defined, bp_valid=1, bp_addr=0x0000000C, pc sequence 0,4,8,C in RUN: no cpu_en while pc=0x0C; state=11, break_hit=1; a step pulse gives 1 cpu_en, then RUN resumes.
REQ-029 step held high across reset release: no cpu_en; a subsequent release and press gives exactly 1 step.
REQ-030 cycle_cnt preloaded (force) to 0xFFFFFFFF, then one step: cycle_cnt=0.
REQ-031 Macro undefined, same stimulus as REQ-028: no halt, break_hit stays 0, cpu_en continues at pc=0x0C.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encodings and step counter width for exec_ctrl
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } exec_state_t;

    // Wide enough for STEP_CYCLES up to 15
    localparam int STEP_CNT_W = 4;

    // Run-mode divider width, covers RUN_DIV up to 2^24
    localparam int DIV_CNT_W = 24;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector whose history register resets high
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic in_q;

    // History resets to 1 so a level already high at reset release is not an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - run/step/breakpoint execution controller; breakpoints under EXEC_CTRL_BREAKPOINT_EN
module exec_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RUN_DIV     = 1,
    parameter int STEP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_valid,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [31:0] cycle_cnt,
    output logic        break_hit
);

    localparam logic [DIV_CNT_W-1:0]  DIV_MAX  = DIV_CNT_W'(RUN_DIV - 1);
    localparam logic [STEP_CNT_W-1:0] STEP_MAX = STEP_CNT_W'(STEP_CYCLES - 1);

    exec_state_t           cur;
    logic [DIV_CNT_W-1:0]  div_cnt;
    logic [STEP_CNT_W-1:0] step_cnt;
    logic                  step_rise;
    logic                  div_tick;
    logic                  bp_hit;

    rise_detect u_step_edge (
        .clk   (clk),
        .reset (reset),
        .in    (step),
        .rise  (step_rise)
    );

`ifdef EXEC_CTRL_BREAKPOINT_EN
    assign bp_hit = bp_valid && (pc == bp_addr);
`else
    // Breakpoint inputs stay on the port list but are not looked at
    logic unused_bp;
    assign unused_bp = &{1'b0, pc, bp_addr, bp_valid};
    assign bp_hit    = 1'b0;
`endif

    assign div_tick = (div_cnt == DIV_MAX);
    assign state    = cur;

    // Enable is decoded in the same cycle as the pc compare so a breakpoint
    // suppresses exactly the advance that would have executed the matching pc
    always_comb begin
        cpu_en = 1'b0;
        case (cur)
            ST_STEP: cpu_en = 1'b1;
            ST_RUN:  cpu_en = run && div_tick && !bp_hit;
            default: cpu_en = 1'b0;
        endcase
    end

    // Mode FSM with run divider, step counter and breakpoint flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= ST_IDLE;
            div_cnt   <= '0;
            step_cnt  <= '0;
            break_hit <= 1'b0;
        end else begin
            case (cur)
                ST_IDLE: begin
                    if (run) begin
                        cur     <= ST_RUN;
                        div_cnt <= '0;
                    end else if (step_rise) begin
                        cur      <= ST_STEP;
                        step_cnt <= '0;
                    end
                end
                ST_STEP: begin
                    if (step_cnt == STEP_MAX) begin
                        cur      <= ST_IDLE;
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        cur     <= ST_IDLE;
                        div_cnt <= '0;
                    end else if (div_tick) begin
                        div_cnt <= '0;
                        if (bp_hit) begin
                            cur       <= ST_BREAK;
                            break_hit <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (!run) begin
                        cur       <= ST_IDLE;
                        break_hit <= 1'b0;
                    end else if (step_rise) begin
                        cur       <= ST_STEP;
                        step_cnt  <= '0;
                        break_hit <= 1'b0;
                    end
                end
                default: cur <= ST_IDLE;
            endcase
        end
    end

    // Count every issued enable cycle, wrapping naturally at 32 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (cpu_en) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb/tb_exec_ctrl.sv - scoreboard bench for exec_ctrl (RUN_DIV=4, STEP_CYCLES=1)
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_valid;
    logic        cpu_en;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic        break_hit;

    logic        pc_clr;
    logic        spacing_on;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_en = -1;
    int          pulses = 0;
    logic [31:0] exp_q[$];
    logic [31:0] snap;

    exec_ctrl #(.RUN_DIV(4), .STEP_CYCLES(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .cpu_en    (cpu_en),
        .state     (state),
        .cycle_cnt (cycle_cnt),
        .break_hit (break_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check(tag, exp_q.size(), 0);
    endtask

    // Environment model of the pipeline: pc advances by 4 on each enable
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pc_clr) pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    // Scoreboard: every enable pops one expected pc
    always @(negedge clk) begin
        if (!reset && cpu_en) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("en_unexpected", pc, 32'hFFFF_FFFF);
            end else begin
                check("en_pc", pc, exp_q.pop_front());
            end
            if (spacing_on && last_en >= 0) check("en_spacing", cyc - last_en, 4);
            last_en = cyc;
        end
    end

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; pc_clr = 1'b1;
        bp_addr = 32'h0; bp_valid = 1'b0; spacing_on = 1'b0;
        tick(); tick();
        check("rst_state", state, 2'b00);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_break_hit", break_hit, 0);
        reset = 1'b0; pc_clr = 1'b0;
        tick();

        // Single step from idle
        exp_q.push_back(pc);
        step = 1'b1;
        tick(); tick(); tick();
        check("step_cnt", cycle_cnt, 1);
        check("step_state", state, 2'b00);
        step = 1'b0;
        tick();

        // Free run at divide-by-4 for 40 run cycles
        snap = cycle_cnt;
        for (int i = 0; i < 10; i++) exp_q.push_back(pc + 32'(4 * i));
        spacing_on = 1'b1; last_en = -1; pulses = 0;
        run = 1'b1;
        for (int i = 0; i < 41; i++) tick();
        run = 1'b0;
        tick();
        check("run_stop_state", state, 2'b00);
        check("run_pulses", pulses, 10);
        check("run_cnt_delta", cycle_cnt - snap, 10);
        spacing_on = 1'b0;
        tick();

        // Breakpoint at 0x0C
        pc_clr = 1'b1; tick(); pc_clr = 1'b0;
        bp_addr = 32'h0000_000C; bp_valid = 1'b1;
`ifdef EXEC_CTRL_BREAKPOINT_EN
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        run = 1'b1;
        begin
            int n = 0;
            while (state != 2'b11 && n < 40) begin tick(); n++; end
        end
        check("bp_state", state, 2'b11);
        check("bp_hit", break_hit, 1);
        check("bp_pc", pc, 32'hC);
        tick(); tick(); tick();
        check("bp_hold_en", cpu_en, 0);
        check("bp_hold_state", state, 2'b11);
        exp_q.push_back(32'hC); exp_q.push_back(32'h10);
        step = 1'b1;
        wait_drain("bp_resume_timeout", 30);
        check("bp_resume_state", state, 2'b01);
        check("bp_resume_hit", break_hit, 0);
`else
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC); exp_q.push_back(32'h10);
        run = 1'b1;
        wait_drain("nobp_timeout", 40);
        check("nobp_state", state, 2'b01);
        check("nobp_hit", break_hit, 0);
`endif
        run = 1'b0;
        tick(); tick();
        step = 1'b0; bp_valid = 1'b0;
        check("bp_end_state", state, 2'b00);
        tick();

        // Reset during run aborts with no further enables
        run = 1'b1;
        tick(); tick();
        reset = 1'b1;
        #1;
        check("midrun_rst_state", state, 2'b00);
        check("midrun_rst_en", cpu_en, 0);
        tick(); tick(); tick(); tick();
        run = 1'b0;
        reset = 1'b0;
        tick();

        // Step key held through reset release issues no step
        step = 1'b1; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("held_state", state, 2'b00);
        check("held_cnt", cycle_cnt, 0);
        step = 1'b0;
        tick();
        exp_q.push_back(pc);
        step = 1'b1;
        tick(); tick(); tick();
        step = 1'b0;
        tick();
        check("held_then_press_cnt", cycle_cnt, 1);

        // Counter wrap
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.cycle_cnt;
        exp_q.push_back(pc);
        step = 1'b1;
        tick(); tick(); tick();
        step = 1'b0;
        tick();
        check("wrap_cnt", cycle_cnt, 0);

        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
